scene_renderer: RTL and testbench
=================================

Name: scene_renderer

Overview:
- Consumer end of the ground-line/player-height interface: reads the three 640-bit ground bitmaps plus player height and state, and drives a 640x480 VGA raster.
- Generates sync timing counters and snapshots the scene once per frame in vertical blanking, so line shifts never tear mid-frame.
- Emits registered 12-bit RGB with syncs.
- Sits between the game core (line_generate, move_player, dead, start_game) and the board VGA pins.

Parameters:
- H_VIS, 640, visible pixels per line
- H_FP / H_SYNC / H_BP, 16 / 96 / 48, horizontal porch and sync widths in pixels
- V_VIS, 480, visible lines
- V_FP / V_SYNC / V_BP, 10 / 2 / 33, vertical porch and sync widths in lines
- Y_TOP / Y_MID / Y_BOT, 120 / 240 / 360, first row of each ground line
- LINE_THICK, 4, ground line thickness in rows
- PLAYER_X, 20, left column of the player sprite (same index the game core samples)
- PLAYER_W, 16, sprite width and height in pixels

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- pix_en  in  1  pixel-rate enable; counters advance only when high
- ground_top  in  640  top ground bitmap; bit i = column i solid
- ground_middle  in  640  middle ground bitmap
- ground_bottom  in  640  bottom ground bitmap
- height  in  9  player sprite top row
- is_dead  in  1  player dead flag
- in_game  in  1  game active flag
- hsync  out  1  horizontal sync, active low
- vsync  out  1  vertical sync, active low
- video_on  out  1  pixel is in the visible area
- rgb  out  12  {R[3:0], G[3:0], B[3:0]}
- frame_start  out  1  one-clk pulse at the start of each frame
- hcount  out  10  current column, unregistered counter
- vcount  out  10  current row, unregistered counter

Behaviour:
- Reset (reset=0, async):
  - hcount=0, vcount=0.
  - hsync=1, vsync=1, video_on=0, rgb=0, frame_start=0.
  - All snapshot registers cleared (no ground, height 0, dead 0, in_game 0).
- Counters (only on clk edges with pix_en=1):
  - hcount runs 0..H_TOTAL-1 (800), then wraps to 0.
  - On an hcount wrap, vcount increments over 0..V_TOTAL-1 (525), then wraps to 0.
  - With pix_en=0, all state holds.
- Raw sync decode:
  - hsync_raw low when hcount in [H_VIS+H_FP, H_VIS+H_FP+H_SYNC-1] = [656, 751].
  - vsync_raw low when vcount in [490, 491].
  - vis_raw = (hcount<640) && (vcount<480).
- Snapshot: on the pix_en cycle with hcount==0 and vcount==V_VIS (first blanking line), latch all three grounds, height, is_dead and in_game into shadow registers. These are the only values used for drawing.
- Pixel classification, computed from the shadow registers at (hcount, vcount):
  - player: hcount in [PLAYER_X, PLAYER_X+PLAYER_W-1] and vcount in [h, h+PLAYER_W-1]. Use 10-bit arithmetic; rows >= 480 are simply never drawn (clip, no wrap).
  - ground: for each line k, vcount in [Y_k, Y_k+LINE_THICK-1] and ground_k[hcount].
- Colour priority (player > ground > background):
  - Player: 12'h0F0 alive, 12'hF00 if dead.
  - Ground: 12'hFFF.
  - Background: 12'h000 when in_game, 12'h008 when not in_game.
  - rgb forced to 0 whenever vis_raw=0.
- Latency: hsync, vsync, video_on and rgb are registered together on pix_en, so all four lag the counters by exactly one pixel and stay mutually aligned.
- frame_start: one-clk pulse on the pix_en cycle where the counters transition to (0,0).
- Boundaries:
  - height in 465..511 is partially or fully clipped.
  - A player overlapping ground shows player colour.
  - Bitmap bits at or above hcount=640 are never indexed.
  - Input changes mid-frame have no visible effect until the next snapshot.
  - Reset mid-frame restarts at (0,0) with blank, inactive outputs.

Decomposition:
- Shared package holds the VGA timing constants (visible, porch and sync widths, totals) and the colour constants.
- One natural sub-module, vga_timing: counters, raw sync/visible decode, frame_start.
- The parent scene_renderer holds the snapshot registers, classification, colour mux and output registers.

Test Plan:
- Reset low mid-frame, then high -> hsync=vsync=1, rgb=0, hcount=vcount=0; first frame_start arrives 420000 pix_en ticks later.
- pix_en always high, free-run -> hsync low for 96 ticks starting one tick after hcount=656; vsync low for exactly 2 lines (rows 490-491); line period 800, frame period 525 lines.
- ground_middle = bit 100 only, latched in vblank -> rgb=FFF only at column 100 for rows 240..243 (one pixel later); all other visible pixels 000.
- Change ground_top from all-zero to all-one while vcount=200 -> rows 120..123 stay black this frame and turn white next frame.
- height=232, is_dead=0, ground_middle bit 25 set -> pixel (25,241) is 0F0. With is_dead=1 at snapshot -> F00. Column 40 on the same rows is background.
- in_game=0, height=475 -> background 008; player drawn only on rows 475..479, nothing on rows 0..10 (no wrap).

Source files
------------

// File: rtl/scene_renderer_pkg.sv
// scene_renderer_pkg: VGA 640x480 timing, scene geometry and colour constants
package scene_renderer_pkg;
   localparam int H_VIS   = 640;
   localparam int H_FP    = 16;
   localparam int H_SYNC  = 96;
   localparam int H_BP    = 48;
   localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
   localparam int V_VIS   = 480;
   localparam int V_FP    = 10;
   localparam int V_SYNC  = 2;
   localparam int V_BP    = 33;
   localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;
   localparam int Y_TOP      = 120;
   localparam int Y_MID      = 240;
   localparam int Y_BOT      = 360;
   localparam int LINE_THICK = 4;
   localparam int PLAYER_X   = 20;
   localparam int PLAYER_W   = 16;
   localparam logic [11:0] C_ALIVE   = 12'h0F0;
   localparam logic [11:0] C_DEAD    = 12'hF00;
   localparam logic [11:0] C_GROUND  = 12'hFFF;
   localparam logic [11:0] C_BG_GAME = 12'h000;
   localparam logic [11:0] C_BG_IDLE = 12'h008;
endpackage

// File: rtl/scene_renderer_vga_timing.sv
// scene_renderer_vga_timing: 800x525 raster counters, raw sync/visible decode, frame_start
// Ports: clk, reset (async, active low), pix_en (advance enable);
//        hcount/vcount (current position), hsync_raw/vsync_raw (active low),
//        vis_raw (visible area), frame_start (registered pulse on wrap to 0,0).
module scene_renderer_vga_timing
   import scene_renderer_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       pix_en,
   output logic [9:0] hcount,
   output logic [9:0] vcount,
   output logic       hsync_raw,
   output logic       vsync_raw,
   output logic       vis_raw,
   output logic       frame_start
);
   logic [9:0] hcount_q, hcount_d, vcount_q, vcount_d;
   logic       frame_start_q, frame_start_d;
   logic       h_last, v_last;
   always_comb begin
      h_last        = hcount_q == 10'(H_TOTAL - 1);
      v_last        = vcount_q == 10'(V_TOTAL - 1);
      hcount_d      = !pix_en ? hcount_q : h_last ? 10'd0 : hcount_q + 10'd1;
      vcount_d      = !(pix_en && h_last) ? vcount_q : v_last ? 10'd0 : vcount_q + 10'd1;
      frame_start_d = pix_en && h_last && v_last;
      hsync_raw     = !(hcount_q >= 10'(H_VIS + H_FP) && hcount_q < 10'(H_VIS + H_FP + H_SYNC));
      vsync_raw     = !(vcount_q >= 10'(V_VIS + V_FP) && vcount_q < 10'(V_VIS + V_FP + V_SYNC));
      vis_raw       = hcount_q < 10'(H_VIS) && vcount_q < 10'(V_VIS);
   end
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         hcount_q      <= '0;
         vcount_q      <= '0;
         frame_start_q <= 1'b0;
      end else begin
         hcount_q      <= hcount_d;
         vcount_q      <= vcount_d;
         frame_start_q <= frame_start_d;
      end
   end
   assign hcount      = hcount_q;
   assign vcount      = vcount_q;
   assign frame_start = frame_start_q;
endmodule

// File: rtl/scene_renderer.sv
// scene_renderer: draws snapshotted ground lines and player sprite onto a 640x480 VGA raster
// Ports: clk, reset (async, active low), pix_en; ground_top/middle/bottom (640-bit bitmaps),
//        height, is_dead, in_game (game state); hsync/vsync/video_on/rgb (registered,
//        one pixel behind hcount/vcount), frame_start, hcount/vcount (live counters).
module scene_renderer
   import scene_renderer_pkg::*;
(
   input  logic         clk,
   input  logic         reset,
   input  logic         pix_en,
   input  logic [639:0] ground_top,
   input  logic [639:0] ground_middle,
   input  logic [639:0] ground_bottom,
   input  logic [8:0]   height,
   input  logic         is_dead,
   input  logic         in_game,
   output logic         hsync,
   output logic         vsync,
   output logic         video_on,
   output logic [11:0]  rgb,
   output logic         frame_start,
   output logic [9:0]   hcount,
   output logic [9:0]   vcount
);
   logic         hsync_raw, vsync_raw, vis_raw;
   logic [639:0] gtop_q, gtop_d, gmid_q, gmid_d, gbot_q, gbot_d;
   logic [8:0]   height_q, height_d;
   logic         dead_q, dead_d, in_game_q, in_game_d;
   logic         hsync_q, hsync_d, vsync_q, vsync_d, video_on_q, video_on_d;
   logic [11:0]  rgb_q, rgb_d, pix;
   logic         snap, player, ground;
   logic [9:0]   px, ptop;

   scene_renderer_vga_timing u_timing (
      .clk         (clk),
      .reset       (reset),
      .pix_en      (pix_en),
      .hcount      (hcount),
      .vcount      (vcount),
      .hsync_raw   (hsync_raw),
      .vsync_raw   (vsync_raw),
      .vis_raw     (vis_raw),
      .frame_start (frame_start)
   );

   always_comb begin
      // Scene is captured once, at the start of vertical blanking, so a frame never tears
      snap      = pix_en && hcount == 10'd0 && vcount == 10'(V_VIS);
      gtop_d    = snap ? ground_top    : gtop_q;
      gmid_d    = snap ? ground_middle : gmid_q;
      gbot_d    = snap ? ground_bottom : gbot_q;
      height_d  = snap ? height        : height_q;
      dead_d    = snap ? is_dead       : dead_q;
      in_game_d = snap ? in_game       : in_game_q;
      // Bitmap index parked at 0 outside the visible area so bits >= 640 are never addressed
      px        = vis_raw ? hcount : 10'd0;
      // 10-bit sprite bounds: height+15 tops out at 526, no wrap back to row 0
      ptop      = {1'b0, height_q};
      player    = hcount >= 10'(PLAYER_X) && hcount < 10'(PLAYER_X + PLAYER_W) &&
                  vcount >= ptop && vcount < ptop + 10'(PLAYER_W);
      ground    = (vcount >= 10'(Y_TOP) && vcount < 10'(Y_TOP + LINE_THICK) && gtop_q[px]) ||
                  (vcount >= 10'(Y_MID) && vcount < 10'(Y_MID + LINE_THICK) && gmid_q[px]) ||
                  (vcount >= 10'(Y_BOT) && vcount < 10'(Y_BOT + LINE_THICK) && gbot_q[px]);
      pix       = !vis_raw ? 12'h000 : player ? (dead_q ? C_DEAD : C_ALIVE) :
                  ground ? C_GROUND : in_game_q ? C_BG_GAME : C_BG_IDLE;
      hsync_d    = pix_en ? hsync_raw : hsync_q;
      vsync_d    = pix_en ? vsync_raw : vsync_q;
      video_on_d = pix_en ? vis_raw   : video_on_q;
      rgb_d      = pix_en ? pix       : rgb_q;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         gtop_q     <= '0;
         gmid_q     <= '0;
         gbot_q     <= '0;
         height_q   <= '0;
         dead_q     <= 1'b0;
         in_game_q  <= 1'b0;
         hsync_q    <= 1'b1;
         vsync_q    <= 1'b1;
         video_on_q <= 1'b0;
         rgb_q      <= '0;
      end else begin
         gtop_q     <= gtop_d;
         gmid_q     <= gmid_d;
         gbot_q     <= gbot_d;
         height_q   <= height_d;
         dead_q     <= dead_d;
         in_game_q  <= in_game_d;
         hsync_q    <= hsync_d;
         vsync_q    <= vsync_d;
         video_on_q <= video_on_d;
         rgb_q      <= rgb_d;
      end
   end

   assign hsync    = hsync_q;
   assign vsync    = vsync_q;
   assign video_on = video_on_q;
   assign rgb      = rgb_q;
endmodule

// File: tb/tb_scene_renderer.sv
// tb_scene_renderer: reference-model and table-driven checks of the scene renderer
module tb_scene_renderer;
   logic         clk = 1'b0, reset = 1'b0, pix_en = 1'b0;
   logic [639:0] ground_top = '0, ground_middle = '0, ground_bottom = '0;
   logic [8:0]   height = '0;
   logic         is_dead = 1'b0, in_game = 1'b0;
   logic         hsync, vsync, video_on, frame_start;
   logic [11:0]  rgb;
   logic [9:0]   hcount, vcount;
   int           vectors = 0, miscompares = 0;

   longint       n = 0;
   logic [639:0] sg [3];
   int           sh = 0;
   bit           sd = 0, si = 0;
   logic         e_hs = 1'b1, e_vs = 1'b1, e_vo = 1'b0, e_fs = 1'b0;
   logic [11:0]  e_rgb = '0;
   logic [11:0]  fb1 [480][640];
   logic [11:0]  fb2 [480][640];
   int           first_fs = -1;

   typedef struct { int f; int x; int y; logic [11:0] c; } pix_t;
   pix_t tbl [$];

   always #5 clk = ~clk;

   scene_renderer dut (
      .clk (clk), .reset (reset), .pix_en (pix_en),
      .ground_top (ground_top), .ground_middle (ground_middle), .ground_bottom (ground_bottom),
      .height (height), .is_dead (is_dead), .in_game (in_game),
      .hsync (hsync), .vsync (vsync), .video_on (video_on), .rgb (rgb),
      .frame_start (frame_start), .hcount (hcount), .vcount (vcount)
   );

   function automatic logic [35:0] outs();
      return {hcount, vcount, hsync, vsync, video_on, rgb, frame_start};
   endfunction

   function automatic logic [639:0] rand640();
      logic [639:0] r;
      for (int i = 0; i < 20; i++) r[i*32 +: 32] = $urandom;
      return r;
   endfunction

   function automatic logic [11:0] ref_rgb(int h, int v);
      if (h >= 640 || v >= 480) return 12'h000;
      if (h >= 20 && h < 36 && v >= sh && v < sh + 16) return sd ? 12'hF00 : 12'h0F0;
      for (int k = 0; k < 3; k++)
         if (v >= 120 * (k + 1) && v < 120 * (k + 1) + 4 && sg[k][h]) return 12'hFFF;
      return si ? 12'h000 : 12'h008;
   endfunction

   task automatic check(input string name, input logic [35:0] got, input logic [35:0] want);
      vectors++;
      if (got !== want) begin
         miscompares++;
         if (miscompares <= 20) $display("FAIL %s tick=%0d got=%h want=%h", name, n, got, want);
      end
   endtask

   task automatic model_reset();
      n = 0; sh = 0; sd = 0; si = 0;
      for (int k = 0; k < 3; k++) sg[k] = '0;
      e_hs = 1'b1; e_vs = 1'b1; e_vo = 1'b0; e_rgb = '0; e_fs = 1'b0;
   endtask

   task automatic step(input bit en);
      int h, v, f;
      pix_en = en;
      @(posedge clk); #1;
      e_fs = 1'b0;
      if (en) begin
         h = int'(n % 800);
         v = int'((n / 800) % 525);
         e_hs  = !(h >= 656 && h <= 751);
         e_vs  = !(v == 490 || v == 491);
         e_vo  = h < 640 && v < 480;
         e_rgb = ref_rgb(h, v);
         e_fs  = h == 799 && v == 524;
         if (h == 0 && v == 480) begin
            sg[0] = ground_top; sg[1] = ground_middle; sg[2] = ground_bottom;
            sh = int'(height); sd = is_dead; si = in_game;
         end
         f = int'(n / 420000);
         if (e_vo && f == 1) fb1[v][h] = rgb;
         if (e_vo && f == 2) fb2[v][h] = rgb;
         n++;
         if (frame_start === 1'b1 && first_fs < 0) first_fs = int'(n);
      end
      check("raster", outs(), {10'(n % 800), 10'((n / 800) % 525), e_hs, e_vs, e_vo, e_rgb, e_fs});
   endtask

   initial begin
      logic [35:0] rst_vals;
      bit a_set, b_set;
      rst_vals = {10'd0, 10'd0, 1'b1, 1'b1, 1'b0, 12'h000, 1'b0};
      a_set = 0; b_set = 0;
      model_reset();
      repeat (3) @(posedge clk);
      #1 check("reset", outs(), rst_vals);
      @(negedge clk) reset = 1'b1;
      for (int i = 0; i < 1500; i++) step($urandom_range(0, 3) != 0);
      // asynchronous reset mid-frame
      @(negedge clk); #2 reset = 1'b0;
      #1 check("async_reset", outs(), rst_vals);
      model_reset();
      repeat (2) begin
         pix_en = 1'b1;
         @(posedge clk); #1 check("reset_hold", outs(), rst_vals);
      end
      @(negedge clk) reset = 1'b1;
      first_fs = -1;
      while (n < 1224000) begin
         if (n < 383000) begin
            ground_top = rand640(); ground_middle = rand640(); ground_bottom = rand640();
            height = 9'($urandom); is_dead = 1'($urandom); in_game = 1'($urandom);
         end else if (!a_set) begin
            a_set = 1;
            ground_top = '0; ground_middle = '0;
            ground_middle[100] = 1'b1; ground_middle[25] = 1'b1;
            ground_bottom = rand640(); ground_bottom[50] = 1'b0;
            height = 9'd232; is_dead = 1'b0; in_game = 1'b1;
         end else if (n >= 580000 && !b_set) begin
            b_set = 1;
            ground_top = '1; ground_bottom = '1;
            height = 9'd475; is_dead = 1'b1; in_game = 1'b0;
         end
         step($urandom_range(0, 15) != 0);
      end
      check("first_frame_start_ticks", 36'(first_fs), 36'd420000);
      tbl.push_back('{1, 100, 240, 12'hFFF}); tbl.push_back('{1, 100, 243, 12'hFFF});
      tbl.push_back('{1, 100, 239, 12'h000}); tbl.push_back('{1, 100, 244, 12'h000});
      tbl.push_back('{1, 101, 241, 12'h000}); tbl.push_back('{1, 99, 242, 12'h000});
      tbl.push_back('{1, 25, 241, 12'h0F0});  tbl.push_back('{1, 40, 241, 12'h000});
      tbl.push_back('{1, 20, 232, 12'h0F0});  tbl.push_back('{1, 35, 247, 12'h0F0});
      tbl.push_back('{1, 36, 240, 12'h000});  tbl.push_back('{1, 19, 240, 12'h000});
      tbl.push_back('{1, 25, 248, 12'h000});  tbl.push_back('{1, 50, 121, 12'h000});
      tbl.push_back('{1, 50, 360, 12'h000});  tbl.push_back('{1, 25, 475, 12'h000});
      tbl.push_back('{2, 50, 120, 12'hFFF});  tbl.push_back('{2, 639, 123, 12'hFFF});
      tbl.push_back('{2, 0, 124, 12'h008});   tbl.push_back('{2, 25, 241, 12'hFFF});
      tbl.push_back('{2, 100, 242, 12'hFFF}); tbl.push_back('{2, 40, 241, 12'h008});
      tbl.push_back('{2, 25, 475, 12'hF00});  tbl.push_back('{2, 20, 479, 12'hF00});
      tbl.push_back('{2, 35, 477, 12'hF00});  tbl.push_back('{2, 36, 476, 12'h008});
      tbl.push_back('{2, 25, 474, 12'h008});  tbl.push_back('{2, 25, 0, 12'h008});
      tbl.push_back('{2, 25, 10, 12'h008});   tbl.push_back('{2, 50, 360, 12'hFFF});
      foreach (tbl[i])
         check($sformatf("pixel_f%0d_x%0d_y%0d", tbl[i].f, tbl[i].x, tbl[i].y),
               36'(tbl[i].f == 1 ? fb1[tbl[i].y][tbl[i].x] : fb2[tbl[i].y][tbl[i].x]),
               36'(tbl[i].c));
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
